execute_operand_forward: RTL and testbench

- Operand-latch stage directly upstream of the execute ALU; consumes the forwarding-register outputs together with the live writeback bus.
- Accepts one decoded instruction per cycle from decode and resolves each GR source operand by priority: live writeback > forwarding register > register-file read.
- Stalls decode on a load-use hazard and presents registered operands to execute through a valid/busy handshake.

---
 rtl/execute_operand_forward.sv | 160 ++++++++++++++++
 tb/tb_execute_operand_forward.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_operand_forward.sv
// Operand-latch stage ahead of the execute ALU: resolves GR sources (writeback > forwarding register > register file)
// and stalls decode on load-use hazards. Define EXECUTE_OPERAND_FORWARD_STAT_EN to enable the hazard-stall counter.
module execute_operand_forward #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iRESET_SYNC,
    input  logic              iPREV_VALID,
    output logic              oPREV_BUSY,
    input  logic              iPREV_SRC0_USE,
    input  logic              iPREV_SRC1_USE,
    input  logic [REG_W-1:0]  iPREV_SRC0,
    input  logic [REG_W-1:0]  iPREV_SRC1,
    input  logic              iPREV_SRC0_SYSREG,
    input  logic              iPREV_SRC1_SYSREG,
    input  logic [DATA_W-1:0] iPREV_SRC0_DATA,
    input  logic [DATA_W-1:0] iPREV_SRC1_DATA,
    input  logic [REG_W-1:0]  iPREV_DEST,
    input  logic              iPREV_DEST_SYSREG,
    input  logic              iPREV_DEST_LOAD,
    input  logic              iWB_GR_VALID,
    input  logic [DATA_W-1:0] iWB_GR_DATA,
    input  logic [REG_W-1:0]  iWB_GR_DEST,
    input  logic              iWB_GR_DEST_SYSREG,
    input  logic              iFDR_GR_VALID,
    input  logic [DATA_W-1:0] iFDR_GR_DATA,
    input  logic [REG_W-1:0]  iFDR_GR_DEST,
    input  logic              iFDR_GR_DEST_SYSREG,
    output logic              oNEXT_VALID,
    input  logic              iNEXT_BUSY,
    output logic [DATA_W-1:0] oNEXT_SRC0_DATA,
    output logic [DATA_W-1:0] oNEXT_SRC1_DATA,
    output logic [REG_W-1:0]  oNEXT_DEST,
    output logic              oNEXT_DEST_SYSREG,
    output logic [31:0]       oSTALL_COUNT
);

    typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_STALL} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   src0_q, src0_d, src1_q, src1_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic                dest_sys_q, dest_sys_d;
    logic                load_pend_q, load_pend_d;
    logic [REG_W-1:0]    load_dest_q, load_dest_d;
    logic                load_sysreg_q, load_sysreg_d;

    logic wb_clr, src0_hz, src1_hz, hz, accept;

    function automatic logic [DATA_W-1:0] resolve(
        input logic              use_src,
        input logic [REG_W-1:0]  src,
        input logic              src_sys,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] res;
        res = rf_data;
        if (use_src) begin
            if (iWB_GR_VALID && iWB_GR_DEST == src && iWB_GR_DEST_SYSREG == src_sys)
                res = iWB_GR_DATA;
            else if (iFDR_GR_VALID && iFDR_GR_DEST == src && iFDR_GR_DEST_SYSREG == src_sys)
                res = iFDR_GR_DATA;
        end
        return res;
    endfunction

    // A writeback to the tracked load dest both retires the load and bypasses its data this cycle.
    assign wb_clr  = load_pend_q && iWB_GR_VALID && iWB_GR_DEST == load_dest_q
                     && iWB_GR_DEST_SYSREG == load_sysreg_q;
    assign src0_hz = iPREV_SRC0_USE && iPREV_SRC0 == load_dest_q && iPREV_SRC0_SYSREG == load_sysreg_q;
    assign src1_hz = iPREV_SRC1_USE && iPREV_SRC1 == load_dest_q && iPREV_SRC1_SYSREG == load_sysreg_q;
    assign hz      = load_pend_q && ((((src0_hz || src1_hz)) && !wb_clr) || iPREV_DEST_LOAD);

    assign oNEXT_VALID = (state_q == ST_FULL);
    assign oPREV_BUSY  = hz || (oNEXT_VALID && iNEXT_BUSY);
    assign accept      = iPREV_VALID && !oPREV_BUSY;

    always_comb begin
        // NOTE: every *_d is given its held value first, so no branch can infer a latch.
        state_d       = state_q;
        src0_d        = src0_q;
        src1_d        = src1_q;
        dest_d        = dest_q;
        dest_sys_d    = dest_sys_q;
        load_pend_d   = load_pend_q;
        load_dest_d   = load_dest_q;
        load_sysreg_d = load_sysreg_q;

        if (accept) begin
            state_d    = ST_FULL;
            src0_d     = resolve(iPREV_SRC0_USE, iPREV_SRC0, iPREV_SRC0_SYSREG, iPREV_SRC0_DATA);
            src1_d     = resolve(iPREV_SRC1_USE, iPREV_SRC1, iPREV_SRC1_SYSREG, iPREV_SRC1_DATA);
            dest_d     = iPREV_DEST;
            dest_sys_d = iPREV_DEST_SYSREG;
        end else if (state_q != ST_FULL || !iNEXT_BUSY) begin
            state_d = (iPREV_VALID && hz) ? ST_STALL : ST_IDLE;
        end

        // A newly accepted load re-arms the tracker even if the old one retires this same cycle.
        if (accept && iPREV_DEST_LOAD) begin
            load_pend_d   = 1'b1;
            load_dest_d   = iPREV_DEST;
            load_sysreg_d = iPREV_DEST_SYSREG;
        end else if (wb_clr) begin
            load_pend_d = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!inRESET || iRESET_SYNC) begin
            state_q       <= ST_IDLE;
            src0_q        <= '0;
            src1_q        <= '0;
            dest_q        <= '0;
            dest_sys_q    <= 1'b0;
            load_pend_q   <= 1'b0;
            load_dest_q   <= '0;
            load_sysreg_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src0_q        <= src0_d;
            src1_q        <= src1_d;
            dest_q        <= dest_d;
            dest_sys_q    <= dest_sys_d;
            load_pend_q   <= load_pend_d;
            load_dest_q   <= load_dest_d;
            load_sysreg_q <= load_sysreg_d;
        end
    end

    assign oNEXT_SRC0_DATA   = src0_q;
    assign oNEXT_SRC1_DATA   = src1_q;
    assign oNEXT_DEST        = dest_q;
    assign oNEXT_DEST_SYSREG = dest_sys_q;

`ifdef EXECUTE_OPERAND_FORWARD_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (iPREV_VALID && hz && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET || iRESET_SYNC)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign oSTALL_COUNT = stall_cnt_q;
`else
    assign oSTALL_COUNT = 32'h0;
`endif

endmodule

// File: tb/tb_execute_operand_forward.sv
// Self-checking bench for execute_operand_forward: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the stage.
module tb_execute_operand_forward;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        p_valid, p_use0, p_use1, p_sys0, p_sys1, p_load, p_dsys;
    logic [4:0]  p_src0, p_src1, p_dest;
    logic [31:0] p_d0, p_d1;
    logic        wb_valid, wb_sys, fdr_valid, fdr_sys;
    logic [4:0]  wb_dest, fdr_dest;
    logic [31:0] wb_data, fdr_data;
    logic        n_busy;
    logic        o_busy, o_valid, o_dsys;
    logic [31:0] o_src0, o_src1, o_cnt;
    logic [4:0]  o_dest;

    always #5 clk = ~clk;

    execute_operand_forward dut (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(flush),
        .iPREV_VALID(p_valid), .oPREV_BUSY(o_busy),
        .iPREV_SRC0_USE(p_use0), .iPREV_SRC1_USE(p_use1),
        .iPREV_SRC0(p_src0), .iPREV_SRC1(p_src1),
        .iPREV_SRC0_SYSREG(p_sys0), .iPREV_SRC1_SYSREG(p_sys1),
        .iPREV_SRC0_DATA(p_d0), .iPREV_SRC1_DATA(p_d1),
        .iPREV_DEST(p_dest), .iPREV_DEST_SYSREG(p_dsys), .iPREV_DEST_LOAD(p_load),
        .iWB_GR_VALID(wb_valid), .iWB_GR_DATA(wb_data), .iWB_GR_DEST(wb_dest), .iWB_GR_DEST_SYSREG(wb_sys),
        .iFDR_GR_VALID(fdr_valid), .iFDR_GR_DATA(fdr_data), .iFDR_GR_DEST(fdr_dest), .iFDR_GR_DEST_SYSREG(fdr_sys),
        .oNEXT_VALID(o_valid), .iNEXT_BUSY(n_busy),
        .oNEXT_SRC0_DATA(o_src0), .oNEXT_SRC1_DATA(o_src1),
        .oNEXT_DEST(o_dest), .oNEXT_DEST_SYSREG(o_dsys),
        .oSTALL_COUNT(o_cnt)
    );

`ifdef EXECUTE_OPERAND_FORWARD_STAT_EN
    localparam logic [31:0] LD_STALLS = 32'd3;
`else
    localparam logic [31:0] LD_STALLS = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: what execute currently holds, and the one outstanding load.
    logic        m_valid = 1'b0, m_dsys = 1'b0, m_pend = 1'b0, m_ldsys = 1'b0;
    logic [31:0] m_src0 = '0, m_src1 = '0, m_cnt = '0;
    logic [4:0]  m_dest = '0, m_ld = '0;
    logic        last_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic u, input logic [4:0] src, input logic sys,
                                         input logic [31:0] rf);
        if (u && wb_valid && wb_dest == src && wb_sys == sys) return wb_data;
        if (u && fdr_valid && fdr_dest == src && fdr_sys == sys) return fdr_data;
        return rf;
    endfunction

    function automatic logic model_blocked();
        logic reads_tracked, wb_delivers;
        if (!m_pend) return 1'b0;
        if (p_load) return 1'b1;
        reads_tracked = (p_use0 && p_src0 == m_ld && p_sys0 == m_ldsys)
                     || (p_use1 && p_src1 == m_ld && p_sys1 == m_ldsys);
        wb_delivers   = wb_valid && wb_dest == m_ld && wb_sys == m_ldsys;
        return reads_tracked && !wb_delivers;
    endfunction

    // One clock: check busy mid-cycle, advance the model at the edge, check outputs just after it.
    task automatic cycle();
        logic        blk, exp_busy, acc, retire;
        logic [31:0] r0, r1;
        @(negedge clk);
        blk      = model_blocked();
        exp_busy = blk || (m_valid && n_busy);
        check("prev_busy", 32'(o_busy), 32'(exp_busy));
        last_busy = exp_busy;
        acc    = p_valid && !exp_busy;
        retire = m_pend && wb_valid && wb_dest == m_ld && wb_sys == m_ldsys;
        r0     = pick(p_use0, p_src0, p_sys0, p_d0);
        r1     = pick(p_use1, p_src1, p_sys1, p_d1);
        @(posedge clk);
        if (!rst_n || flush) begin
            m_valid = 1'b0; m_src0 = '0; m_src1 = '0; m_dest = '0; m_dsys = 1'b0;
            m_pend = 1'b0; m_ld = '0; m_ldsys = 1'b0; m_cnt = '0;
        end else begin
            if (acc) begin
                m_valid = 1'b1; m_src0 = r0; m_src1 = r1; m_dest = p_dest; m_dsys = p_dsys;
            end else if (!n_busy) begin
                m_valid = 1'b0;
            end
            if (acc && p_load) begin
                m_pend = 1'b1; m_ld = p_dest; m_ldsys = p_dsys;
            end else if (retire) begin
                m_pend = 1'b0;
            end
`ifdef EXECUTE_OPERAND_FORWARD_STAT_EN
            if (p_valid && blk && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
        end
        #1;
        check("next_valid", 32'(o_valid), 32'(m_valid));
        check("src0", o_src0, m_src0);
        check("src1", o_src1, m_src1);
        check("dest", 32'(o_dest), 32'(m_dest));
        check("dest_sys", 32'(o_dsys), 32'(m_dsys));
        check("stall_cnt", o_cnt, m_cnt);
    endtask

    task automatic set_prev(input logic v, input logic u0, input logic [4:0] s0, input logic [31:0] d0,
                            input logic ld, input logic [4:0] dst);
        p_valid = v; p_use0 = u0; p_src0 = s0; p_sys0 = 1'b0; p_d0 = d0;
        p_use1 = 1'b0; p_src1 = 5'd0; p_sys1 = 1'b0; p_d1 = 32'h5;
        p_load = ld; p_dest = dst; p_dsys = 1'b0;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] d, input logic s, input logic [31:0] x);
        wb_valid = v; wb_dest = d; wb_sys = s; wb_data = x;
    endtask

    task automatic set_fdr(input logic v, input logic [4:0] d, input logic s, input logic [31:0] x);
        fdr_valid = v; fdr_dest = d; fdr_sys = s; fdr_data = x;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; n_busy = 1'b0;
        set_prev(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        set_wb(1'b0, 5'd0, 1'b0, 32'h0);
        set_fdr(1'b0, 5'd0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_src0", o_src0, 32'h0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_cnt", o_cnt, 32'h0);
        rst_n = 1'b1;

        // Priority: writeback over forwarding register over register file; sysreg must match.
        set_prev(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 5'd7);
        set_fdr(1'b1, 5'd3, 1'b0, 32'h22);
        set_wb(1'b1, 5'd3, 1'b0, 32'h33);
        cycle(); check("wb_priority", o_src0, 32'h33);
        set_wb(1'b0, 5'd3, 1'b0, 32'h33);
        cycle(); check("fdr_priority", o_src0, 32'h22);
        set_fdr(1'b1, 5'd3, 1'b1, 32'h22);
        cycle(); check("sysreg_no_match", o_src0, 32'h11);
        set_fdr(1'b0, 5'd0, 1'b0, 32'h0);

        // Load-use: three stall cycles, then a same-cycle writeback is bypassed.
        set_prev(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        cycle();
        set_prev(1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            cycle(); check("ld_stall_busy", 32'(o_busy), 32'd1);
        end
        set_wb(1'b1, 5'd5, 1'b0, 32'hCAFE);
        cycle();
        check("ld_bypass_data", o_src0, 32'hCAFE);
        check("ld_bypass_valid", 32'(o_valid), 32'd1);
        check("ld_stall_count", o_cnt, LD_STALLS);
        set_wb(1'b0, 5'd0, 1'b0, 32'h0);

        // Execute back-pressure holds the outputs and stalls decode.
        set_prev(1'b1, 1'b0, 5'd0, 32'hA1, 1'b0, 5'd1);
        cycle(); check("hold_first", o_src0, 32'hA1);
        n_busy = 1'b1;
        set_prev(1'b1, 1'b0, 5'd0, 32'hB2, 1'b0, 5'd2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("hold_src0", o_src0, 32'hA1);
            check("hold_dest", 32'(o_dest), 32'd1);
            check("hold_busy", 32'(o_busy), 32'd1);
        end
        n_busy = 1'b0;
        cycle(); check("release_src0", o_src0, 32'hB2);

        // Flush while stalled on a pending load discards it.
        set_prev(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        cycle();
        set_prev(1'b1, 1'b1, 5'd5, 32'h77, 1'b0, 5'd3);
        repeat (2) cycle();
        check("flush_pre_busy", 32'(o_busy), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_busy", 32'(o_busy), 32'd0);
        cycle();
        check("post_flush_valid", 32'(o_valid), 32'd1);
        check("post_flush_src0", o_src0, 32'h77);

        // Mid-stream reset, then four back-to-back instructions.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_src0", o_src0, 32'h0);
        check("mid_rst_cnt", o_cnt, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_prev(1'b1, 1'b0, 5'd0, 32'h100 + 32'(i), 1'b0, 5'(i));
            cycle();
            check("b2b_valid", 32'(o_valid), 32'd1);
            check("b2b_src0", o_src0, 32'h100 + 32'(i));
        end
        set_prev(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        cycle();
        check("b2b_drain", 32'(o_valid), 32'd0);

        // Random traffic; decode keeps an offered instruction stable while it is refused.
        for (int n = 0; n < 3000; n++) begin
            if (!(p_valid && last_busy)) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_use0  = $urandom_range(0, 1) == 1;
                p_use1  = $urandom_range(0, 1) == 1;
                p_src0  = 5'($urandom_range(0, 3));
                p_src1  = 5'($urandom_range(0, 3));
                p_sys0  = $urandom_range(0, 7) == 0;
                p_sys1  = $urandom_range(0, 7) == 0;
                p_d0    = $urandom;
                p_d1    = $urandom;
                p_load  = $urandom_range(0, 3) == 0;
                p_dest  = 5'($urandom_range(0, 3));
                p_dsys  = $urandom_range(0, 7) == 0;
            end
            set_wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom);
            set_fdr($urandom_range(0, 1) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom);
            n_busy = $urandom_range(0, 2) == 0;
            flush  = $urandom_range(0, 63) == 0;
            rst_n  = $urandom_range(0, 127) != 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
